neuron_input_serializer: RTL and testbench

//  Transmit side of the neuron's byte-wide input port. Accepts whole input vectors
//  (spike frames or weight words) over a valid/ready handshake and drives them as
//  VEC_W/8 byte beats, most-significant byte first, onto the neuron's 8-bit input.
//  The neuron shift register then holds the vector aligned after the last beat.
//  For weight words, emits a one-cycle active-low neuron reset after the last beat,

---
 rtl/neuron_input_serializer_pkg.sv | 12 +
 rtl/neuron_input_serializer.sv | 105 ++++++++++
 tb/tb_neuron_input_serializer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/neuron_input_serializer_pkg.sv
// Shared definitions for the neuron input port: byte width and serializer FSM states.
package neuron_input_serializer_pkg;

    localparam int NRN_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        PULSE = 2'd2
    } state_e;

endpackage

// File: rtl/neuron_input_serializer.sv
// Splits whole input vectors into MSB-first byte beats for the neuron's 8-bit input,
// following each weight word with a one-cycle active-low neuron reset.
module neuron_input_serializer
    import neuron_input_serializer_pkg::*;
#(
    parameter int VEC_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [VEC_W-1:0]      s_data,
    input  logic                  s_is_weight,
    output logic [NRN_BYTE_W-1:0] nrn_byte,
    output logic                  nrn_rst_n,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int N_BEATS = VEC_W / NRN_BYTE_W;
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
    localparam logic ONE_BEAT = (N_BEATS == 1);

    state_e                  state_q;
    logic [BEAT_W-1:0]       beat_q;
    logic [BEAT_W-1:0]       beat_d;
    logic [VEC_W-1:0]        sreg_q;
    logic                    is_w_q;
    logic [NRN_BYTE_W-1:0]   nrn_byte_q;
    logic                    nrn_rst_n_q;
    logic                    s_ready_q;
    logic                    frame_done_q;
    logic                    busy_q;
    logic                    accept;

    assign accept = s_valid && s_ready_q;
    assign beat_d = beat_q + BEAT_W'(1);

    // s_ready_q is only ever set for IDLE or a spike frame's last beat, so an accept
    // takes priority over the per-state transitions below.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            sreg_q       <= '0;
            is_w_q       <= 1'b0;
            nrn_byte_q   <= '0;
            nrn_rst_n_q  <= 1'b0;
            s_ready_q    <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            nrn_rst_n_q  <= 1'b1;
            frame_done_q <= 1'b0;
            if (accept) begin
                state_q      <= SEND;
                beat_q       <= '0;
                sreg_q       <= s_data << NRN_BYTE_W;
                is_w_q       <= s_is_weight;
                nrn_byte_q   <= s_data[VEC_W-1 -: NRN_BYTE_W];
                frame_done_q <= ONE_BEAT;
                s_ready_q    <= ONE_BEAT && !s_is_weight;
                busy_q       <= 1'b1;
            end else begin
                case (state_q)
                    SEND: begin
                        if (beat_q != LAST_BEAT) begin
                            beat_q       <= beat_d;
                            sreg_q       <= sreg_q << NRN_BYTE_W;
                            nrn_byte_q   <= sreg_q[VEC_W-1 -: NRN_BYTE_W];
                            frame_done_q <= (beat_d == LAST_BEAT);
                            s_ready_q    <= (beat_d == LAST_BEAT) && !is_w_q;
                            busy_q       <= 1'b1;
                        end else if (is_w_q) begin
                            state_q     <= PULSE;
                            nrn_byte_q  <= '0;
                            nrn_rst_n_q <= 1'b0;
                            s_ready_q   <= 1'b0;
                            busy_q      <= 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            nrn_byte_q <= '0;
                            s_ready_q  <= 1'b1;
                            busy_q     <= 1'b0;
                        end
                    end
                    default: begin
                        state_q    <= IDLE;
                        nrn_byte_q <= '0;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign nrn_byte   = nrn_byte_q;
    assign nrn_rst_n  = nrn_rst_n_q;
    assign s_ready    = s_ready_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_neuron_input_serializer.sv
// Bench for neuron_input_serializer: transaction-queue reference model plus a neuron model.
module tb_neuron_input_serializer;

    localparam int VEC_W = 32;
    localparam int NB    = VEC_W / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             s_valid;
    logic             s_ready;
    logic [VEC_W-1:0] s_data;
    logic             s_is_weight;
    logic [7:0]       nrn_byte;
    logic             nrn_rst_n;
    logic             frame_done;
    logic             busy;

    always #5 clk = ~clk;

    neuron_input_serializer #(.VEC_W(VEC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_is_weight (s_is_weight),
        .nrn_byte    (nrn_byte),
        .nrn_rst_n   (nrn_rst_n),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    typedef struct packed {
        logic [7:0] b;
        logic       rn;
        logic       rdy;
        logic       done;
        logic       bsy;
    } exp_t;

    exp_t             q[$];
    bit               rst_out;
    bit               accepted;
    int               errors = 0;
    int               checks = 0;
    logic [VEC_W-1:0] nx = '0;
    logic [VEC_W-1:0] nw = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check outputs for the current cycle, then advance the model at the edge.
    task automatic cycle();
        exp_t cur;
        exp_t e;
        if (rst_out)          cur = '0;
        else if (q.size() > 0) cur = q[0];
        else                   cur = '{b: 8'h00, rn: 1'b1, rdy: 1'b1, done: 1'b0, bsy: 1'b0};
        chk("nrn_byte",   {24'b0, nrn_byte},   {24'b0, cur.b});
        chk("nrn_rst_n",  {31'b0, nrn_rst_n},  {31'b0, cur.rn});
        chk("s_ready",    {31'b0, s_ready},    {31'b0, cur.rdy});
        chk("frame_done", {31'b0, frame_done}, {31'b0, cur.done});
        chk("busy",       {31'b0, busy},       {31'b0, cur.bsy});
        if (!nrn_rst_n) begin
            nw = nx;
            nx = '0;
        end else begin
            nx = {nx[VEC_W-9:0], nrn_byte};
        end
        @(posedge clk);
        accepted = s_valid && cur.rdy && !reset;
        if (reset) begin
            q.delete();
            rst_out = 1'b1;
        end else begin
            rst_out = 1'b0;
            if (q.size() > 0) void'(q.pop_front());
            if (accepted) begin
                for (int i = 0; i < NB; i++) begin
                    e.b    = s_data[VEC_W-1-8*i -: 8];
                    e.rn   = 1'b1;
                    e.done = (i == NB - 1);
                    e.rdy  = e.done && !s_is_weight;
                    e.bsy  = 1'b1;
                    q.push_back(e);
                end
                if (s_is_weight) q.push_back('{b: 8'h00, rn: 1'b0, rdy: 1'b0, done: 1'b0, bsy: 1'b1});
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [VEC_W-1:0] d, input logic w);
        int n = 0;
        s_data      = d;
        s_is_weight = w;
        s_valid     = 1'b1;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 20);
        chk("accept", {31'b0, accepted}, 32'd1);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        reset       = 1'b1;
        s_valid     = 1'b0;
        s_data      = '0;
        s_is_weight = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_out = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;

        send(32'hA1B2C3D4, 1'b0);
        idle(6);

        send(32'hFFFF0000, 1'b1);
        idle(6);
        chk("neuron_w", nw, 32'hFFFF0000);
        chk("neuron_x", nx, 32'h0);

        repeat (3) send($urandom, 1'b0);
        idle(6);

        send($urandom, 1'b0);
        send($urandom, 1'b1);
        idle(8);

        send($urandom, 1'b0);
        s_valid = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle(2);
        send($urandom, 1'b0);
        idle(6);

        repeat (6) begin
            s_valid = 1'b1;
            #2;
            s_valid = 1'b0;
            #1;
            cycle();
        end

        repeat (10) begin
            send($urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
